// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the pong game-state logic.
//   state_t   : game FSM encoding (IDLE, SERVE, PLAY, OVER)
//   SCORE_W   : width of each score output
//   MAX_DIGIT : highest score the single-digit renderer can draw
//   DIR_*     : serve direction encoding for ball logic
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int   SCORE_W   = 8;
  localparam int   MAX_DIGIT = 9;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/rise_detect.sv
// rise_detect: 1-bit rising-edge detector with a registered history bit.
//   clk, reset_n : clock and synchronous active-low reset
//   rst_val      : value loaded into the history bit during reset
//   d            : level input
//   rise         : high for the cycle where d=1 and the previous sample was 0
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic rst_val,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!reset_n) prev <= rst_val;
    else          prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/score_keeper.sv
// score_keeper: pong game-state and scoring engine.
//   clk, reset_n          : pixel clock, synchronous active-low reset
//   FRAME_TICK            : one-cycle pulse per frame, paces the serve pause
//   START                 : start button level (edge detected)
//   MISS_LEFT/MISS_RIGHT  : ball-past-goal levels (edge detected)
//   PLAYER_ONE/PLAYER_TWO : binary scores, 0..WIN_SCORE
//   BALL_HOLD             : park the ball at centre
//   SERVE_DIR             : 0 = serve left, 1 = serve right
//   GAME_OVER, WINNER     : end-of-game flag and winning player
//
// state | meaning
// IDLE  | waiting for START after reset, ball held
// SERVE | pause of PAUSE_FRAMES frame ticks, ball held
// PLAY  | ball in motion, waiting for a miss
// OVER  | someone reached WIN_SCORE, scores frozen until START
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = MAX_DIGIT,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               FRAME_TICK,
  input  logic               START,
  input  logic               MISS_LEFT,
  input  logic               MISS_RIGHT,
  output logic [SCORE_W-1:0] PLAYER_ONE,
  output logic [SCORE_W-1:0] PLAYER_TWO,
  output logic               BALL_HOLD,
  output logic               SERVE_DIR,
  output logic               GAME_OVER,
  output logic               WINNER
);

  localparam logic [SCORE_W-1:0] WIN_CMP    = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         PAUSE_LOAD = 8'(PAUSE_FRAMES);

  state_t     state;
  logic [7:0] pause_cnt;
  logic       start_ev;
  logic       miss_l_ev;
  logic       miss_r_ev;

  // History resets to 1 so a level already high at reset release is not an event.
  rise_detect u_start_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .rst_val (1'b1),
    .d       (START),
    .rise    (start_ev)
  );

  rise_detect u_miss_l_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .rst_val (1'b1),
    .d       (MISS_LEFT),
    .rise    (miss_l_ev)
  );

  rise_detect u_miss_r_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .rst_val (1'b1),
    .d       (MISS_RIGHT),
    .rise    (miss_r_ev)
  );

  wire [SCORE_W-1:0] p1_next = PLAYER_ONE + 1'b1;
  wire [SCORE_W-1:0] p2_next = PLAYER_TWO + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      pause_cnt  <= '0;
      PLAYER_ONE <= '0;
      PLAYER_TWO <= '0;
      BALL_HOLD  <= 1'b1;
      SERVE_DIR  <= DIR_LEFT;
      GAME_OVER  <= 1'b0;
      WINNER     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          BALL_HOLD <= 1'b1;
          GAME_OVER <= 1'b0;
          if (start_ev) begin
            PLAYER_ONE <= '0;
            PLAYER_TWO <= '0;
            SERVE_DIR  <= DIR_LEFT;
            pause_cnt  <= PAUSE_LOAD;
            state      <= SERVE;
          end
        end

        SERVE: begin
          BALL_HOLD <= 1'b1;
          if (FRAME_TICK) begin
            if (pause_cnt == 8'd1) begin
              pause_cnt <= '0;
              BALL_HOLD <= 1'b0;
              state     <= PLAY;
            end else begin
              pause_cnt <= pause_cnt - 8'd1;
            end
          end
        end

        PLAY: begin
          // Simultaneous misses cancel: no point, rally continues.
          if (miss_r_ev && !miss_l_ev) begin
            PLAYER_ONE <= p1_next;
            SERVE_DIR  <= DIR_RIGHT;
            BALL_HOLD  <= 1'b1;
            if (p1_next == WIN_CMP) begin
              WINNER    <= 1'b0;
              GAME_OVER <= 1'b1;
              state     <= OVER;
            end else begin
              pause_cnt <= PAUSE_LOAD;
              state     <= SERVE;
            end
          end else if (miss_l_ev && !miss_r_ev) begin
            PLAYER_TWO <= p2_next;
            SERVE_DIR  <= DIR_LEFT;
            BALL_HOLD  <= 1'b1;
            if (p2_next == WIN_CMP) begin
              WINNER    <= 1'b1;
              GAME_OVER <= 1'b1;
              state     <= OVER;
            end else begin
              pause_cnt <= PAUSE_LOAD;
              state     <= SERVE;
            end
          end
        end

        OVER: begin
          BALL_HOLD <= 1'b1;
          GAME_OVER <= 1'b1;
          if (start_ev) begin
            PLAYER_ONE <= '0;
            PLAYER_TWO <= '0;
            WINNER     <= 1'b0;
            SERVE_DIR  <= DIR_LEFT;
            GAME_OVER  <= 1'b0;
            pause_cnt  <= PAUSE_LOAD;
            state      <= SERVE;
          end
        end

        default: begin
          BALL_HOLD <= 1'b1;
          GAME_OVER <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // A score can never be incremented once it has reached WIN_SCORE.
  always_ff @(posedge clk) begin
    if (reset_n && state == PLAY) begin
      if (miss_r_ev && !miss_l_ev)
        assert (PLAYER_ONE < WIN_CMP) else $error("score_keeper: PLAYER_ONE overflow");
      if (miss_l_ev && !miss_r_ev)
        assert (PLAYER_TWO < WIN_CMP) else $error("score_keeper: PLAYER_TWO overflow");
    end
  end
`endif

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-state and scoring engine for pong; the producer of the PLAYER_ONE/PLAYER_TWO values that the on-screen score renderer consumes.
- Takes miss events from ball logic, a start button and a once-per-frame tick.
- Maintains both scores, sequences serve/pause/play/game-over, and tells ball logic when to hold the ball and which way to serve.
- Sits between ball/paddle logic and the score renderer, in the pixel clock domain.

Parameters:
- WIN_SCORE, 9, score that ends the game; legal range 1..9 because the renderer draws a single ASCII digit.
- PAUSE_FRAMES, 60, FRAME_TICK pulses spent in each SERVE pause; legal range 1..255.

Ports:
- clk  input  1  pixel clock.
- reset_n  input  1  synchronous reset, active-low.
- FRAME_TICK  input  1  one-cycle pulse per frame, e.g. at start of vertical blank.
- START  input  1  debounced start button, level.
- MISS_LEFT  input  1  level; high while the ball is past the left goal line. Awards a point to player two.
- MISS_RIGHT  input  1  level; high while the ball is past the right goal line. Awards a point to player one.
- PLAYER_ONE  output  8  player one score, binary 0..WIN_SCORE.
- PLAYER_TWO  output  8  player two score, binary 0..WIN_SCORE.
- BALL_HOLD  output  1  1 = ball logic must park the ball at centre and not move it.
- SERVE_DIR  output  1  0 = serve toward the left (player one), 1 = serve toward the right (player two).
- GAME_OVER  output  1  high in the OVER state.
- WINNER  output  1  0 = player one won, 1 = player two won; valid while GAME_OVER=1.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset (reset_n=0 sampled on a clk rising edge):
  - state=IDLE, PLAYER_ONE=0, PLAYER_TWO=0, BALL_HOLD=1, SERVE_DIR=0, GAME_OVER=0, WINNER=0.
  - Pause counter and edge-detect history registers are cleared.
  - Reset mid-game applies the same values on the next edge; there is no partial state.
- Edge detection:
  - START, MISS_LEFT and MISS_RIGHT are registered once.
  - An event is the rising edge: current=1 and previous=0.
  - Held levels therefore produce exactly one event.
  - An input already high when reset releases does not produce an event, because history is cleared to 1 on reset.
- All outputs are registered; state changes are visible the cycle after the event cycle.
- States:
  - IDLE: BALL_HOLD=1.
    - A START event clears both scores and sets SERVE_DIR=0.
    - Next state is SERVE, with the pause counter loaded with PAUSE_FRAMES.
  - SERVE: BALL_HOLD=1.
    - Each FRAME_TICK decrements the counter.
    - The tick that takes the counter from 1 to 0 moves the block to PLAY.
    - Miss events are ignored in this state.
  - PLAY: BALL_HOLD=0.
    - MISS_RIGHT event alone: PLAYER_ONE+1, SERVE_DIR=1.
    - MISS_LEFT event alone: PLAYER_TWO+1, SERVE_DIR=0.
    - If the new score equals WIN_SCORE: go to OVER, with WINNER = 0 for player one or 1 for player two.
    - Otherwise: go to SERVE with the counter reloaded.
    - Both miss events in the same cycle: no score change, stay in PLAY.
  - OVER: BALL_HOLD=1, GAME_OVER=1, scores frozen.
    - A START event clears both scores and WINNER, sets SERVE_DIR=0, and goes to SERVE.
- Arithmetic:
  - Scores are 8-bit with the upper bits always 0.
  - An increment past WIN_SCORE cannot occur. The design asserts this (simulation-only check).
- FRAME_TICK coincident with the entry cycle into SERVE does not count; the first decrement is the next tick.
- Illegal or unused state encodings go to IDLE.

Decomposition:
- Shared package pong_pkg holds:
  - the state encoding: IDLE, SERVE, PLAY, OVER (2 bits);
  - SCORE_W=8;
  - MAX_DIGIT=9;
  - direction constants DIR_LEFT=0, DIR_RIGHT=1.
- One sub-module, rise_detect: a 1-bit registered rising-edge detector with a reset value input. It is instantiated three times (START, MISS_LEFT, MISS_RIGHT).
- The FSM and scores live in score_keeper.

Test Plan:
- Reset, then START held high for 100 cycles:
  - exactly one transition to SERVE;
  - with PAUSE_FRAMES=3, PLAY is entered 1 cycle after the 3rd FRAME_TICK;
  - BALL_HOLD falls to 0.
- In PLAY, MISS_RIGHT held high for 50 cycles:
  - PLAYER_ONE goes 0→1 exactly once;
  - SERVE_DIR=1, state=SERVE, BALL_HOLD=1.
- MISS_LEFT and MISS_RIGHT rising in the same cycle during PLAY:
  - both scores unchanged, still PLAY;
  - MISS_LEFT asserted during SERVE is ignored.
- WIN_SCORE=3, player two scores three times:
  - PLAYER_TWO=3, GAME_OVER=1, WINNER=1, BALL_HOLD=1;
  - further misses leave the scores unchanged.
- From OVER, a START pulse:
  - PLAYER_ONE=PLAYER_TWO=0, GAME_OVER=0, SERVE_DIR=0, state=SERVE.
- reset_n pulled low for 1 cycle while in PLAY with score 2:1:
  - all outputs return to their reset values;
  - MISS_RIGHT held high across the reset release does not score.
